// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multi-cycle multiply/divide sequencer.
//   - OP_* encodings of the 2-bit op field
//   - muldiv_state_t FSM state enum
//   - MULDIV_ITER iteration count (one iteration per operand bit)
//   - DIV0_LO quotient value reported for a divide by zero
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam int MULDIV_ITER = 32;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_RUN,
        S_FIX,
        S_DONE
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational radix-2 iteration.
//   acc_i    : current accumulator, 2*WIDTH+1 bits
//   opnd_i   : multiplicand (multiply) or divisor (divide), magnitude
//   is_div_i : 1 = restoring shift-subtract, 0 = shift-add
//   acc_o    : accumulator after this iteration
// Multiply layout: {carry, hi, lo}, multiplier consumed from lo[0].
// Divide layout:   {sign, rem, quo}, dividend shifted out of quo.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH:0] acc_i,
    input  logic [WIDTH-1:0] opnd_i,
    input  logic             is_div_i,
    output logic [2*WIDTH:0] acc_o
);

    logic [WIDTH:0]   mul_sum;
    logic [2*WIDTH:0] div_shift;
    logic [WIDTH:0]   div_trial;

    always_comb begin
        // Top bit is always 0 between multiply iterations, so including it
        // in the add is harmless and keeps the whole accumulator in use.
        mul_sum   = acc_i[2*WIDTH:WIDTH] + (acc_i[0] ? {1'b0, opnd_i} : '0);
        div_shift = {acc_i[2*WIDTH-1:0], 1'b0};
        div_trial = div_shift[2*WIDTH:WIDTH] - {1'b0, opnd_i};
        if (is_div_i) begin
            // Non-negative trial result: remainder absorbs the divisor.
            if (!div_trial[WIDTH]) begin
                acc_o = {div_trial, div_shift[WIDTH-1:1], 1'b1};
            end else begin
                acc_o = div_shift;
            end
        end else begin
            acc_o = {1'b0, mul_sum, acc_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer for the EX stage.
//   clk, rst          : clock, asynchronous active-high reset
//   start, op         : request strobe (sampled in IDLE) and operation
//   src1, src2        : rs / rt operands
//   cancel            : pipeline flush, aborts any in-flight operation
//   stallreq          : hold IF/ID/EX while the operation is in progress
//   busy              : FSM not idle
//   result_valid      : one-cycle HI/LO write enable
//   hi, lo            : last completed result (product or remainder/quotient)
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MULDIV_ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             cancel,
    output logic             stallreq,
    output logic             busy,
    output logic             result_valid,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam int AW = 2 * WIDTH + 1;

    muldiv_state_t    state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] src1_q, src1_d;
    logic [WIDTH-1:0] src2_q, src2_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic               is_div, is_signed;
    logic               s1, s2;
    logic [WIDTH-1:0]   mag1, mag2;
    logic [AW-1:0]      step_acc;
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);
    assign is_signed = (op_q == OP_MULT) || (op_q == OP_DIV);
    assign s1        = is_signed & src1_q[WIDTH-1];
    assign s2        = is_signed & src2_q[WIDTH-1];
    assign mag1      = s1 ? -src1_q : src1_q;
    assign mag2      = s2 ? -src2_q : src2_q;

    assign prod      = acc_q[2*WIDTH-1:0];
    assign prod_fix  = neg_quo_q ? -prod : prod;
    assign quo_fix   = neg_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    assign rem_fix   = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc_i    (acc_q),
        .opnd_i   (opnd_q),
        .is_div_i (is_div),
        .acc_o    (step_acc)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        src1_d       = src1_q;
        src2_d       = src2_q;
        acc_d        = acc_q;
        opnd_d       = opnd_q;
        cnt_d        = cnt_q;
        neg_quo_d    = neg_quo_q;
        neg_rem_d    = neg_rem_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        stallreq     = 1'b0;
        result_valid = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                // cancel in IDLE masks a same-cycle start
                if (start && !cancel) begin
                    stallreq = 1'b1;
                    op_d     = op;
                    src1_d   = src1;
                    src2_d   = src2;
                    state_d  = S_PREP;
                end
            end
            S_PREP: begin
                stallreq  = 1'b1;
                neg_quo_d = s1 ^ s2;
                neg_rem_d = s1;
                cnt_d     = CW'(WIDTH - 1);
                // Lower half is pre-loaded with the operand that gets shifted
                // out (multiplier or dividend); everything above is cleared.
                if (is_div) begin
                    acc_d  = {{(WIDTH + 1){1'b0}}, mag1};
                    opnd_d = mag2;
                end else begin
                    acc_d  = {{(WIDTH + 1){1'b0}}, mag2};
                    opnd_d = mag1;
                end
                if (is_div && (src2_q == '0)) begin
                    hi_d    = src1_q;
                    lo_d    = WIDTH'(DIV0_LO);
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                stallreq = 1'b1;
                acc_d    = step_acc;
                if (cnt_q == '0) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_FIX: begin
                stallreq = 1'b1;
                if (is_div) begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                result_valid = !cancel;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Flush: abandon the operation without touching the architectural HI/LO.
        if (cancel && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
            acc_q     <= '0;
            opnd_q    <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
            acc_q     <= acc_d;
            opnd_q    <= opnd_d;
            cnt_q     <= cnt_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed self-checking bench for muldiv_ctrl.
module tb_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] src1 = '0;
    logic [31:0] src2 = '0;
    logic        cancel = 1'b0;
    logic        stallreq;
    logic        busy;
    logic        result_valid;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;

    muldiv_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .src1         (src1),
        .src2         (src2),
        .cancel       (cancel),
        .stallreq     (stallreq),
        .busy         (busy),
        .result_valid (result_valid),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clk = ~clk;

    // Drive a start strobe through the sampling edge (edge 0); returns #1
    // after edge 0 with start released. st0 = stallreq in the start cycle.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         output int st0);
        @(negedge clk);
        start = 1'b1; op = o; src1 = a; src2 = b;
        #1;
        st0 = stallreq ? 1 : 0;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Issue an op and watch it; k counts negedges after edge 0.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input int tail, output int lat, output int stalls,
                          output int pulses, output logic [31:0] rhi, output logic [31:0] rlo);
        int st0;
        lat = -1; stalls = 0; pulses = 0; rhi = 'x; rlo = 'x;
        issue(o, a, b, st0);
        stalls = st0;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (stallreq) stalls++;
            if (result_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = k; rhi = hi; rlo = lo;
                end
            end
            if (lat >= 0 && k >= lat + tail) break;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({stallreq, busy, result_valid} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: got stall/busy/rv=%b hi=%h lo=%h, want 000 0 0",
                     {stallreq, busy, result_valid}, hi, lo);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_busy: got %b want 0", busy);
        end
        $display("test_reset done");
    endtask

    task automatic test_multu_max();
        int lat, stalls, pulses; logic [31:0] rhi, rlo;
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, lat, stalls, pulses, rhi, rlo);
        checks++;
        if (rhi !== 32'hFFFF_FFFE || rlo !== 32'h0000_0001) begin
            errors++;
            $display("FAIL multu_max_result: got hi=%h lo=%h want fffffffe 00000001", rhi, rlo);
        end
        checks++;
        if (lat !== 35) begin
            errors++;
            $display("FAIL multu_max_latency: got %0d want 35", lat);
        end
        checks++;
        if (stalls !== 35) begin
            errors++;
            $display("FAIL multu_max_stall_cycles: got %0d want 35", stalls);
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL multu_max_valid_pulses: got %0d want 1", pulses);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL multu_max_idle_after: busy=%b want 0", busy);
        end
        $display("MULTU ffffffff*ffffffff -> hi=%h lo=%h lat=%0d", rhi, rlo, lat);
    endtask

    task automatic test_mult_neg();
        int lat, stalls, pulses; logic [31:0] rhi, rlo;
        run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 2, lat, stalls, pulses, rhi, rlo);
        checks++;
        if (rhi !== 32'hFFFF_FFFF || rlo !== 32'hFFFF_FFEB) begin
            errors++;
            $display("FAIL mult_neg: got hi=%h lo=%h want ffffffff ffffffeb", rhi, rlo);
        end
        $display("MULT -3*7 -> hi=%h lo=%h", rhi, rlo);
    endtask

    task automatic test_div_signed();
        int lat, stalls, pulses; logic [31:0] rhi, rlo;
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 2, lat, stalls, pulses, rhi, rlo);
        checks++;
        if (rhi !== 32'hFFFF_FFFF || rlo !== 32'hFFFF_FFFD) begin
            errors++;
            $display("FAIL div_neg: got hi=%h lo=%h want ffffffff fffffffd", rhi, rlo);
        end
        checks++;
        if (lat !== 35) begin
            errors++;
            $display("FAIL div_latency: got %0d want 35", lat);
        end
        $display("DIV -7/2 -> hi=%h lo=%h", rhi, rlo);
    endtask

    task automatic test_divu();
        int lat, stalls, pulses; logic [31:0] rhi, rlo;
        run_op(2'b11, 32'd100, 32'd7, 2, lat, stalls, pulses, rhi, rlo);
        checks++;
        if (rhi !== 32'd2 || rlo !== 32'd14) begin
            errors++;
            $display("FAIL divu_100_7: got hi=%0d lo=%0d want 2 14", rhi, rlo);
        end
        $display("DIVU 100/7 -> hi=%0d lo=%0d", rhi, rlo);
    endtask

    task automatic test_div_intmin();
        int lat, stalls, pulses; logic [31:0] rhi, rlo;
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 2, lat, stalls, pulses, rhi, rlo);
        checks++;
        if (rhi !== 32'd0 || rlo !== 32'h8000_0000) begin
            errors++;
            $display("FAIL div_intmin: got hi=%h lo=%h want 00000000 80000000", rhi, rlo);
        end
        $display("DIV 80000000/ffffffff -> hi=%h lo=%h", rhi, rlo);
    endtask

    task automatic test_div_zero();
        int lat, stalls, pulses; logic [31:0] rhi, rlo;
        run_op(2'b11, 32'd5, 32'd0, 4, lat, stalls, pulses, rhi, rlo);
        checks++;
        if (rhi !== 32'd5 || rlo !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div_zero_result: got hi=%h lo=%h want 00000005 ffffffff", rhi, rlo);
        end
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL div_zero_latency: got %0d want 2", lat);
        end
        checks++;
        if (stalls !== 2 || pulses !== 1) begin
            errors++;
            $display("FAIL div_zero_stall_pulse: got stalls=%0d pulses=%0d want 2 1", stalls, pulses);
        end
        $display("DIVU 5/0 -> hi=%h lo=%h lat=%0d", rhi, rlo, lat);
    endtask

    task automatic test_cancel();
        int st0, pulses;
        logic [31:0] prev_hi, prev_lo;
        prev_hi = 32'd5; prev_lo = 32'hFFFF_FFFF;
        issue(2'b01, 32'd1234, 32'd5678, st0);
        repeat (11) @(negedge clk);  // RUN cycle 10
        checks++;
        if (busy !== 1'b1 || stallreq !== 1'b1) begin
            errors++;
            $display("FAIL cancel_running: got busy=%b stall=%b want 1 1", busy, stallreq);
        end
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        checks++;
        if (busy !== 1'b0 || stallreq !== 1'b0) begin
            errors++;
            $display("FAIL cancel_to_idle: got busy=%b stall=%b want 0 0", busy, stallreq);
        end
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (result_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL cancel_no_valid: got %0d pulses want 0", pulses);
        end
        checks++;
        if (hi !== prev_hi || lo !== prev_lo) begin
            errors++;
            $display("FAIL cancel_hilo_kept: got hi=%h lo=%h want %h %h", hi, lo, prev_hi, prev_lo);
        end
        $display("cancel at RUN cycle 10 -> busy=%b hi=%h lo=%h", busy, hi, lo);
    endtask

    task automatic test_start_ignored();
        int st0, lat, pulses, busy_cnt;
        logic [31:0] rhi, rlo;
        lat = -1; pulses = 0; busy_cnt = 0; rhi = 'x; rlo = 'x;
        issue(2'b01, 32'd3, 32'd5, st0);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (k == 5) begin
                start = 1'b1; op = 2'b11; src1 = 32'd1000; src2 = 32'd3;
            end else begin
                start = 1'b0;
            end
            if (result_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = k; rhi = hi; rlo = lo;
                end
            end
            if (lat >= 0 && k > lat && busy) busy_cnt++;
            if (lat >= 0 && k >= lat + 10) break;
        end
        checks++;
        if (rhi !== 32'd0 || rlo !== 32'd15 || lat !== 35) begin
            errors++;
            $display("FAIL start_ignored_result: got hi=%0d lo=%0d lat=%0d want 0 15 35", rhi, rlo, lat);
        end
        checks++;
        if (pulses !== 1 || busy_cnt !== 0) begin
            errors++;
            $display("FAIL start_not_queued: got pulses=%0d busy_after=%0d want 1 0", pulses, busy_cnt);
        end
        $display("start during RUN ignored -> hi=%0d lo=%0d", rhi, rlo);
    endtask

    task automatic test_reset_mid();
        int st0, lat, stalls, pulses; logic [31:0] rhi, rlo;
        issue(2'b00, 32'd9, 32'd9, st0);
        repeat (21) @(negedge clk);  // RUN cycle 20
        rst = 1'b1;
        #1;
        checks++;
        if ({stallreq, busy, result_valid} !== 3'b000 || hi !== 32'd0 || lo !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got stall/busy/rv=%b hi=%h lo=%h want 000 0 0",
                     {stallreq, busy, result_valid}, hi, lo);
        end
        @(negedge clk);
        rst = 1'b0;
        run_op(2'b01, 32'd6, 32'd7, 2, lat, stalls, pulses, rhi, rlo);
        checks++;
        if (rhi !== 32'd0 || rlo !== 32'd42 || lat !== 35) begin
            errors++;
            $display("FAIL reset_mid_then_multu: got hi=%0d lo=%0d lat=%0d want 0 42 35", rhi, rlo, lat);
        end
        $display("reset mid-RUN then MULTU 6*7 -> hi=%0d lo=%0d", rhi, rlo);
    endtask

    task automatic test_back_to_back();
        int lat, stalls, pulses; logic [31:0] rhi, rlo;
        run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 0, lat, stalls, pulses, rhi, rlo);
        checks++;
        if (rhi !== 32'd1 || rlo !== 32'd0) begin
            errors++;
            $display("FAIL b2b_first: got hi=%h lo=%h want 00000001 00000000", rhi, rlo);
        end
        // Next start lands in the first IDLE cycle after DONE.
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 2, lat, stalls, pulses, rhi, rlo);
        checks++;
        if (rhi !== 32'd1 || rlo !== 32'hFFFF_FFFD || lat !== 35) begin
            errors++;
            $display("FAIL b2b_second: got hi=%h lo=%h lat=%0d want 00000001 fffffffd 35", rhi, rlo, lat);
        end
        $display("back-to-back DIV 7/-2 -> hi=%h lo=%h", rhi, rlo);
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_mult_neg();
        test_div_signed();
        test_divu();
        test_div_intmin();
        test_div_zero();
        test_cancel();
        test_start_ignored();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide sequencer for the EX stage. It accepts one MULT/MULTU/DIV/DIVU request at a time and runs a 32-iteration radix-2 shift-add or restoring shift-subtract loop. While it runs it holds the pipeline through `stallreq`, then presents the 64-bit result as `hi`/`lo` for the EX→ID HI/LO bypass and the HI/LO write-back path. It replaces the single-cycle combinational multiply/divide path so that EX timing closes.

## Interface
Parameters:
- `WIDTH`, 32, operand width. The iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  request strobe; sampled only in IDLE
- `op`  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- `src1`  in  WIDTH  rs operand (multiplicand / dividend)
- `src2`  in  WIDTH  rt operand (multiplier / divisor)
- `cancel`  in  1  pipeline flush; aborts an in-flight operation
- `stallreq`  out  1  hold the IF/ID/EX stages
- `busy`  out  1  FSM not in IDLE
- `result_valid`  out  1  one-cycle pulse; HI/LO write enable
- `hi`  out  WIDTH  product[63:32] / remainder
- `lo`  out  WIDTH  product[31:0] / quotient

## Operation
States: IDLE, PREP, RUN, FIX, DONE.
- **IDLE:** `start` latches `op`, `src1`, `src2` → PREP.
- **PREP:**
  - Signed ops (MULT, DIV) convert operands to magnitudes.
  - Record `neg_q = s1^s2` and `neg_r = s1`.
  - Clear the accumulator and load the 5-bit counter with `WIDTH-1`.
  - A divide with `src2 == 0` sets `hi = src1`, `lo = 32'hFFFF_FFFF` → DONE directly.
  - Otherwise → RUN.
- **RUN:** one iteration per cycle, `WIDTH` cycles.
  - Multiply: if the multiplier LSB is 1, add the multiplicand to the upper accumulator half, then shift the 64-bit accumulator right by 1 (carry into bit 63).
  - Divide: shift {rem, quo} left by 1, trial-subtract the divisor from rem. If the result is non-negative, commit it and set quo[0]=1.
  - When the counter reaches 0 → FIX.
- **FIX:** two's-complement negation applied as follows, then the result is registered into `hi`/`lo` → DONE.
  - MULT: negate the 64-bit product if `neg_q`.
  - DIV: negate the quotient if `neg_q`, and negate the remainder if `neg_r`.
- **DONE:** `result_valid` = 1 for this cycle only → IDLE.
- `stallreq` = (IDLE & `start`) | PREP | RUN | FIX. It is combinational in IDLE so the issuing instruction freezes in EX in the same cycle. It is low in DONE so the instruction advances with its result.
- `busy` = state ≠ IDLE.
- `cancel` (synchronous) in PREP/RUN/FIX/DONE → IDLE next edge, with no `result_valid` and `hi`/`lo` unchanged. `cancel` in IDLE masks `start`.
- `start` asserted outside IDLE is ignored and never queued.
- `hi`/`lo` hold the last completed result until the next DONE.
- Arithmetic: the accumulator is 2×WIDTH+1 bits, giving the divide trial subtraction a sign bit.
- INT_MIN ÷ −1 produces `lo` = 0x8000_0000, `hi` = 0 (wraps, no trap).

## Timing
- Reset values: state IDLE, `stallreq` 0, `busy` 0, `result_valid` 0, `hi` 0, `lo` 0, counter 0. Reset mid-operation discards all work immediately.
- Edges are counted from the edge that samples `start` (edge 0):
  - PREP after edge 0.
  - RUN after edges 1 … 32.
  - FIX after edge 33.
  - DONE after edge 34, during which `result_valid` = 1.
  - IDLE after edge 35.
- Normal latency is 35 cycles from start to `result_valid`, with `stallreq` high for 35 cycles.
- Divide-by-zero: DONE after edge 1, so latency is 2 cycles.
- A back-to-back `start` is accepted at the earliest in the first IDLE cycle after DONE.

## Structure
- `muldiv_pkg` holds:
  - op encodings `OP_MULT/OP_MULTU/OP_DIV/OP_DIVU`
  - state enum `muldiv_state_t`
  - the `MULDIV_ITER` constant
  - `DIV0_LO` = 32'hFFFF_FFFF
- Sub-module `muldiv_step` is combinational and performs one iteration. Inputs: accumulator, operand, `is_div`. Output: next accumulator.
- `muldiv_ctrl` owns the FSM, counter, sign bookkeeping and output registers.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → after 35 cycles, `hi` = 0xFFFF_FFFE, `lo` = 0x0000_0001, `result_valid` pulses once, `stallreq` high exactly 35 cycles.
- MULT −3 × 7 → `hi` = 0xFFFF_FFFF, `lo` = 0xFFFF_FFEB.
- DIV −7 ÷ 2 → `lo` = 0xFFFF_FFFD (−3), `hi` = 0xFFFF_FFFF (−1). DIVU 100 ÷ 7 → `lo` = 14, `hi` = 2.
- DIV 0x8000_0000 ÷ 0xFFFF_FFFF → `lo` = 0x8000_0000, `hi` = 0. DIVU 5 ÷ 0 → `result_valid` 2 cycles after start, `hi` = 5, `lo` = 0xFFFF_FFFF.
- `cancel` at RUN cycle 10 → IDLE next cycle, no `result_valid`, `hi`/`lo` keep prior values. `start` pulsed during RUN → ignored.
- Assert `rst` at RUN cycle 20 → all outputs 0 immediately. A new MULTU 6 × 7 afterwards → `lo` = 42, `hi` = 0.
